// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with prescaled stepping,
// synchronous clear/load, wrap-or-saturate limits, a terminal-count pulse and a
// parallel binary copy of the count.
// Optional compare output is built only when BCD_COUNTER_CMP_EN is defined.
// Interface timing: there is no valid/ready handshake. All control inputs are
// sampled on every rising clk edge, and every output is a register that is
// valid in every cycle.
module bcd_updown_counter #(
  parameter int DIGITS    = 4,
  parameter int MAX_VALUE = 9999,
  parameter int BIN_W     = 14,
  parameter int PRESCALE  = 1,
  parameter int WRAP      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_COUNTER_CMP_EN
  input  logic [4*DIGITS-1:0]   cmp_val,
  output logic                  match,
`endif
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [BIN_W-1:0]      count_bin,
  output logic                  tc,
  output logic                  load_err
);

  localparam int BW    = 4 * DIGITS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  function automatic logic [BW-1:0] int_to_bcd(input int v);
    logic [BW-1:0] res;
    int r;
    res = '0;
    r   = v;
    for (int i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BW-1:0]    MAX_BCD  = int_to_bcd(MAX_VALUE);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VALUE);
  localparam logic [BW-1:0]    MAX_DEC  = BW'(MAX_VALUE);

  logic [PRE_W-1:0] pre, pre_nxt;
  logic [BW-1:0]    bcd_nxt, bcd_inc, bcd_dec;
  logic [BIN_W-1:0] bin_nxt, load_bin;
  logic [BW-1:0]    load_dec;
  logic             tc_nxt, err_nxt;
  logic             tick, at_max, at_zero, load_bad, load_nib_bad;

  assign tick    = en && (pre == PRE_LAST);
  assign at_max  = (count_bin == MAX_BIN);
  assign at_zero = (count_bin == '0);

  // Digit-wise BCD increment: a 9 rolls to 0 and carries into the next digit.
  always_comb begin
    logic carry;
    bcd_inc = count_bcd;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Digit-wise BCD decrement: a 0 rolls to 9 and borrows from the next digit.
  always_comb begin
    logic borrow;
    bcd_dec = count_bcd;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Validate load_val: every nibble must be a decimal digit and the value must
  // not exceed the limit. The decimal value doubles as the binary load value.
  always_comb begin
    load_dec     = '0;
    load_nib_bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      load_dec     = load_dec * BW'(10) + BW'(load_val[4*i +: 4]);
      load_nib_bad = load_nib_bad | (load_val[4*i +: 4] > 4'd9);
    end
    load_bad = load_nib_bad || (load_dec > MAX_DEC);
    load_bin = BIN_W'(load_dec);
  end

  // Next-state selection with priority clear > load > step.
  always_comb begin
    bcd_nxt = count_bcd;
    bin_nxt = count_bin;
    pre_nxt = pre;
    tc_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (clear) begin
      bcd_nxt = '0;
      bin_nxt = '0;
      pre_nxt = '0;
    end else if (load) begin
      pre_nxt = '0;
      if (load_bad) begin
        bcd_nxt = MAX_BCD;
        bin_nxt = MAX_BIN;
        err_nxt = 1'b1;
      end else begin
        bcd_nxt = load_val;
        bin_nxt = load_bin;
      end
    end else if (tick) begin
      pre_nxt = '0;
      if (dir) begin
        if (at_max) begin
          tc_nxt = 1'b1;
          if (WRAP != 0) begin
            bcd_nxt = '0;
            bin_nxt = '0;
          end
        end else begin
          bcd_nxt = bcd_inc;
          bin_nxt = count_bin + BIN_W'(1);
        end
      end else begin
        if (at_zero) begin
          tc_nxt = 1'b1;
          if (WRAP != 0) begin
            bcd_nxt = MAX_BCD;
            bin_nxt = MAX_BIN;
          end
        end else begin
          bcd_nxt = bcd_dec;
          bin_nxt = count_bin - BIN_W'(1);
        end
      end
    end else if (en) begin
      pre_nxt = pre + PRE_W'(1);
    end
  end

  // Count, prescaler and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_bcd <= '0;
      count_bin <= '0;
      pre       <= '0;
      tc        <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      count_bcd <= bcd_nxt;
      count_bin <= bin_nxt;
      pre       <= pre_nxt;
      tc        <= tc_nxt;
      load_err  <= err_nxt;
    end
  end

`ifdef BCD_COUNTER_CMP_EN
  // Compare the registered count; match therefore trails the count by one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else begin
      match <= (count_bcd == cmp_val);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: three counter configurations share one stimulus
// stream (wrap/prescale 1, saturate/prescale 4/limit 5000, saturate/prescale 1).
// An integer-valued reference model predicts each cycle's outputs into a queue
// that a negedge monitor drains and compares. Define BCD_COUNTER_CMP_EN to also
// check the compare output.
module tb_bcd_updown_counter;

  localparam int N  = 3;
  localparam int EW = 33;
  localparam int W  = N * EW;
  localparam int P_MAX  [N] = '{9999, 5000, 9999};
  localparam int P_PS   [N] = '{1, 4, 1};
  localparam int P_WRAP [N] = '{1, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] bcd [N];
  logic [13:0] bin [N];
  logic        tc  [N];
  logic        err [N];
`ifdef BCD_COUNTER_CMP_EN
  logic [15:0] cmp_val = '0;
  logic        match [N];
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bcd_updown_counter #(
      .DIGITS(4), .MAX_VALUE(P_MAX[g]), .BIN_W(14),
      .PRESCALE(P_PS[g]), .WRAP(P_WRAP[g])
    ) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
      .load_val(load_val),
`ifdef BCD_COUNTER_CMP_EN
      .cmp_val(cmp_val), .match(match[g]),
`endif
      .count_bcd(bcd[g]), .count_bin(bin[g]), .tc(tc[g]), .load_err(err[g])
    );
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
  endtask

  // reference model: plain integer count and prescale position per instance
  int mval [N] = '{0, 0, 0};
  int mpre [N] = '{0, 0, 0};
  logic [W-1:0] ent;
  bit tcb, errb, mb, bad;
  int dec;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mval[k] = 0;
        mpre[k] = 0;
      end
    end else begin
      ent = '0;
      for (int k = 0; k < N; k++) begin
        mb = 1'b0;
`ifdef BCD_COUNTER_CMP_EN
        mb = (to_bcd(mval[k]) == cmp_val);
`endif
        tcb  = 1'b0;
        errb = 1'b0;
        if (clear) begin
          mval[k] = 0;
          mpre[k] = 0;
        end else if (load) begin
          mpre[k] = 0;
          bad = 1'b0;
          dec = 0;
          for (int i = 3; i >= 0; i--) begin
            if (load_val[4*i +: 4] > 4'd9) bad = 1'b1;
            dec = dec * 10 + int'(load_val[4*i +: 4]);
          end
          if (dec > P_MAX[k]) bad = 1'b1;
          if (bad) begin
            mval[k] = P_MAX[k];
            errb = 1'b1;
          end else begin
            mval[k] = dec;
          end
        end else if (en) begin
          if (mpre[k] == P_PS[k] - 1) begin
            mpre[k] = 0;
            if (dir) begin
              if (mval[k] == P_MAX[k]) begin
                tcb = 1'b1;
                if (P_WRAP[k] != 0) mval[k] = 0;
              end else mval[k] = mval[k] + 1;
            end else begin
              if (mval[k] == 0) begin
                tcb = 1'b1;
                if (P_WRAP[k] != 0) mval[k] = P_MAX[k];
              end else mval[k] = mval[k] - 1;
            end
          end else begin
            mpre[k] = mpre[k] + 1;
          end
        end
        ent[k*EW +: EW] = {mb, to_bcd(mval[k]), 14'(mval[k]), tcb, errb};
      end
      exp_q.push_back(ent);
    end
  end

  // monitor: every non-reset edge yields one expected entry
  logic [W-1:0] got_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      for (int k = 0; k < N; k++) begin
        check($sformatf("inst%0d_outputs", k), {bcd[k], bin[k], tc[k], err[k]},
              got_e[k*EW +: 32]);
`ifdef BCD_COUNTER_CMP_EN
        check($sformatf("inst%0d_match", k), {31'b0, match[k]}, {31'b0, got_e[k*EW+32]});
`endif
      end
    end
  end

  // driver tasks
  task automatic set_in(input logic e, input logic d, input logic c, input logic l,
                        input logic [15:0] lv);
    en = e; dir = d; clear = c; load = l; load_val = lv;
  endtask

  task automatic drive(input logic e, input logic d, input logic c, input logic l,
                       input logic [15:0] lv);
    @(negedge clk);
    set_in(e, d, c, l, lv);
  endtask

  int r;

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++)
      check("reset_state", {bcd[k], bin[k], tc[k], err[k]}, 32'h0);
    rst = 1'b0;

    // wrap through 9999 on instance 0
    drive(0, 1, 0, 1, 16'h9998);
    drive(1, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0);
    check("wrap_up_tc", {15'b0, bcd[0], tc[0]}, {15'b0, 16'h0000, 1'b1});
    drive(0, 1, 0, 0, 16'h0);
    check("wrap_up_next", {16'b0, bcd[0]}, {16'b0, 16'h0001});

    // saturate at 0 going down on instance 2
    drive(0, 0, 0, 1, 16'h0002);
    repeat (3) drive(1, 0, 0, 0, 16'h0);
    drive(0, 0, 0, 0, 16'h0);
    check("sat_down", {2'b0, bcd[2], bin[2]}, {2'b0, 16'h0000, 14'd0});
    check("sat_down_tc", {31'b0, tc[2]}, 32'd1);

    // prescale 4 on instance 1, with an en gap mid-period
    drive(0, 1, 1, 0, 16'h0);
    repeat (4) drive(1, 1, 0, 0, 16'h0);
    drive(1, 1, 0, 0, 16'h0);
    check("prescale_first_step", {16'b0, bcd[1]}, {16'b0, 16'h0001});
    repeat (2) drive(1, 1, 0, 0, 16'h0);
    repeat (3) drive(0, 1, 0, 0, 16'h0);
    repeat (8) drive(1, 1, 0, 0, 16'h0);

    // invalid loads clamp to the limit
    drive(0, 1, 0, 1, 16'h12A4);
    drive(0, 1, 0, 0, 16'h0);
    check("clamp_nibble", {14'b0, bcd[1], err[1], tc[1]}, {14'b0, 16'h5000, 1'b1, 1'b0});
    drive(0, 1, 0, 1, 16'h9999);
    drive(0, 1, 0, 0, 16'h0);
    check("clamp_range", {14'b0, bcd[1], err[1], tc[1]}, {14'b0, 16'h5000, 1'b1, 1'b0});
    check("load_9999_ok", {15'b0, bcd[0], err[0]}, {15'b0, 16'h9999, 1'b0});

    // clear beats load
    drive(0, 1, 0, 1, 16'h0137);
    drive(1, 1, 1, 1, 16'h12A4);
    drive(0, 1, 0, 0, 16'h0);
    check("clear_wins", {1'b0, bcd[0], bin[0], err[0]}, 32'h0);

    // asynchronous reset mid-count
    drive(0, 1, 0, 1, 16'h0137);
    repeat (3) drive(1, 1, 0, 0, 16'h0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++)
      check("async_reset", {bcd[k], bin[k], tc[k], err[k]}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) drive(1, 1, 0, 0, 16'h0);

`ifdef BCD_COUNTER_CMP_EN
    cmp_val = 16'h0005;
    drive(0, 1, 1, 0, 16'h0);
    repeat (10) drive(1, 1, 0, 0, 16'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 3);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
            (r == 0) ? 16'($urandom) :
            (r == 1) ? to_bcd($urandom_range(4990, 5010)) :
                       to_bcd($urandom_range(0, 9999)));
`ifdef BCD_COUNTER_CMP_EN
      if (i % 40 == 0) cmp_val = to_bcd($urandom_range(0, 20));
`endif
    end

    drive(0, 0, 0, 0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD up/down counter; next generation of the display-side 0..9999 counter in the VGA path.
- Adds configurable digit count and modulus, direction control, prescaled stepping, synchronous load/clear, wrap-or-saturate mode and a terminal-count pulse.
- Drives the score/value digit renderer with BCD digits and the rest of the logic with a parallel binary value.

Parameters:
- DIGITS, 4: number of BCD digits; count_bcd is 4*DIGITS bits wide.
- MAX_VALUE, 9999: upper count limit; must be < 10**DIGITS. The range is 0..MAX_VALUE.
- BIN_W, 14: width of count_bin; must satisfy 2**BIN_W > MAX_VALUE.
- PRESCALE, 1: enabled clk cycles per count step; must be >= 1.
- WRAP, 1: 1 = wrap at the limits; 0 = saturate at the limits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; gates the prescaler
- dir  in  1  1 = count up, 0 = count down
- clear  in  1  synchronous clear to 0
- load  in  1  synchronous load of load_val
- load_val  in  4*DIGITS  BCD load value; digit 0 in bits [3:0]
- count_bcd  out  4*DIGITS  registered BCD count
- count_bin  out  BIN_W  registered binary equivalent of count_bcd
- tc  out  1  one-cycle pulse on a limit event (wrap or saturate hit)
- load_err  out  1  one-cycle pulse when load_val was invalid and got clamped

Behaviour:
- Reset (rst=1, asynchronous): count_bcd=0, count_bin=0, tc=0, load_err=0, prescaler=0.
- Priority per clk edge: clear > load > step.
- Prescaler:
  - Internal counter pre runs 0..PRESCALE-1 only while en=1 and holds while en=0.
  - tick = en && (pre == PRESCALE-1); pre returns to 0 on tick.
  - clear and load also zero pre.
  - With PRESCALE=1, tick = en.
- Step:
  - On tick, the count moves one unit in the direction given by dir.
  - count_bcd and count_bin update on the same edge; both are registered with no combinational path from inputs.
  - Latency from a sampled tick to the new value is 1 clk.
- BCD arithmetic:
  - Count up: a digit at 9 rolls to 0 and carries into the next digit.
  - Count down: a digit at 0 rolls to 9 and borrows from the next digit.
  - Carry/borrow ripple is combinational inside one cycle.
- count_bin: tracks the count with ±1 in parallel and is loaded or cleared together with count_bcd. It must always equal the decimal value of count_bcd.
- Up at MAX_VALUE on tick:
  - WRAP=1: next value 0, tc=1.
  - WRAP=0: hold MAX_VALUE, tc=1 on every such tick.
- Down at 0 on tick:
  - WRAP=1: next value MAX_VALUE, tc=1.
  - WRAP=0: hold 0, tc=1.
- tc is 0 in all other cycles. It is registered and asserts in the same cycle the new count appears.
- Load:
  - If any nibble of load_val is > 9, or its decimal value is > MAX_VALUE, the count becomes MAX_VALUE and load_err=1 for one cycle.
  - Otherwise count = load_val.
  - A load never produces tc.
- clear: count=0, tc=0, load_err=0. clear=1 together with load=1 means clear wins and load_err stays 0.
- en=0 freezes the count and pre. load and clear still act.
- A dir change between ticks takes effect at the next tick; there is no glitch and pre is unaffected.
- rst asserted mid-count zeroes everything immediately. The first tick after release occurs PRESCALE enabled cycles later.

Optional Feature:
- Macro: BCD_COUNTER_CMP_EN.
- Defined:
  - Adds input cmp_val [4*DIGITS-1:0] (BCD) and output match (1 bit, registered, reset 0).
  - match=1 in every cycle where the registered count_bcd equals cmp_val; it lags the count by 1 clk.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- DIGITS=4, MAX=9999, PRESCALE=1, WRAP=1: load 9998, en=1, dir=1 -> count 9999, then 0000 with tc=1 on that edge only, then 0001.
- WRAP=0, dir=0 from 0002: three ticks -> counts 0001, 0000, 0000; tc=1 on the third edge; count_bin tracks as 1, 0, 0.
- PRESCALE=4, en=1 from 0: count reaches 1 after 4 clks and 2 after 8 clks. Toggling en low for 3 clks mid-period delays the next step by exactly 3 clks.
- load_val=0x12A4 (invalid nibble) and load_val=0x9999 with MAX=5000 -> count=5000 with load_err=1 for one cycle in both cases; tc=0.
- clear and load asserted together while counting at 0137 -> count 0000, count_bin 0, load_err 0. Async rst mid-count -> all outputs 0 before the next clk edge.
- With BCD_COUNTER_CMP_EN defined, cmp_val=0x0005, counting up from 0 -> match=1 in exactly one cycle, the cycle after count_bcd shows 0005.
